// File: rtl/multicycle_seq.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and arbitrates the shared memory port.
module multicycle_seq #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       brUn,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       retire,
    output logic       trap
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic is_branch, is_load, is_store, is_jump, illegal, taken, timed_out;

    assign is_branch = (opcode == OpBranch);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_jump   = (opcode == OpJal) || (opcode == OpJalr);
    assign timed_out = !mem_ready && (wait_q == WaitLast);

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OpReg, OpImm, OpLui, OpAuipc, OpJal, OpJalr: illegal = 1'b0;
            OpBranch: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OpLoad:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OpStore:  illegal = (funct3 > 3'b010);
            default:  illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = eq;
            3'b001:         taken = !eq;
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        brUn      = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;
        trap      = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (timed_out) begin
                    state_d = StTrap;
                end
            end
            StDecode: state_d = illegal ? StTrap : StExec;
            StExec: begin
                if (is_branch) begin
                    // funct3[1] separates the unsigned compares (BLTU/BGEU)
                    brUn     = !funct3[1];
                    pc_write = 1'b1;
                    pc_sel   = taken;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timed_out) begin
                    state_d = StTrap;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_sel    = is_jump;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StTrap: trap = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    // Any cycle without a stalled request (including state entry and handshakes) clears it.
    assign wait_d = (mem_req && !mem_ready) ? wait_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle control sequencer for the RV32I core, replacing single-cycle decode for the PC, IR, register-file and memory strobes.
- Steps each instruction through IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
- Arbitrates one shared memory port between instruction fetch and data access using a req/ready handshake.
- Bounds every memory wait with a timeout counter.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for mem_ready before trapping. Must be at least 1.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]; valid from DECODE onward
- eq  in  1  branch comparator: rs1 == rs2
- lt  in  1  branch comparator: rs1 < rs2, signedness set by brUn
- mem_ready  in  1  memory accepts or completes the current request this cycle
- mem_req  out  1  memory request on the shared port
- mem_we  out  1  store request (meaningful only while mem_req is high)
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write  out  1  latch memory read data into IR
- pc_write  out  1  update PC this cycle
- pc_sel  out  1  PC source: 0 = PC+4, 1 = ALU target
- brUn  out  1  comparator mode: 1 = signed, 0 = unsigned
- reg_write  out  1  register-file write enable
- state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky error flag (illegal instruction or memory timeout)

Behaviour:
- Outputs are a combinational function of the state register plus eq, lt and mem_ready. State and wait_cnt are the only registers.
- Reset: while rst is high on a clock edge, state <= IDLE and wait_cnt <= 0. Reset takes priority over every transition, including mid-MEM and TRAP. In IDLE all outputs are 0 and state=0.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - On mem_ready, assert ir_write and go to DECODE.
- DECODE: one cycle, no strobes. Legal opcodes are 0110011, 0010011, 0110111, 0010111, 1100011, 0000011, 0100011, 1101111, 1100111.
  - Illegal opcode, branch funct3 of 010 or 011, load funct3 of 011, 110 or 111, or store funct3 above 010: go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - Branch: brUn=1 for funct3 000/001/100/101, brUn=0 for 110/111.
  - Branch taken conditions: BEQ eq, BNE !eq, BLT and BLTU lt, BGE and BGEU !lt.
  - Branch completes in EXEC: pc_write=1, pc_sel=taken, retire=1, then FETCH.
  - Load/store: go to MEM.
  - All other legal opcodes: go to WB.
  - brUn is 0 outside a branch EXEC.
- MEM: mem_req=1, iord=1, mem_we=1 for stores and 0 for loads.
  - On mem_ready, a load goes to WB.
  - On mem_ready, a store asserts pc_write=1, pc_sel=0, retire=1 and goes to FETCH.
- WB: reg_write=1, pc_write=1, retire=1, then FETCH.
  - pc_sel=1 for JAL/JALR, 0 otherwise.
- Cycle counts with mem_ready tied high:
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Wait counter:
  - Clears on entry to FETCH or MEM and on every handshake.
  - Increments each cycle mem_req=1 && mem_ready=0.
  - If wait_cnt == MEM_TIMEOUT-1 and mem_ready=0, go to TRAP. No strobe fires on that cycle.
- A handshake on the same cycle the timeout is reached counts as success.
- TRAP: trap=1 and every other strobe is 0. Exit only via rst.
- retire and pc_write are asserted at most once per instruction. ir_write only in FETCH; reg_write only in WB.

Test Plan:
- Hold rst high for 3 cycles, then release → during reset state=0 and all outputs 0; one IDLE cycle; FETCH with mem_req=1, iord=0 on the second cycle after release.
- ADD (opcode 0110011), mem_ready=1 → states 1,2,3,5; in WB reg_write=1, pc_write=1, pc_sel=0, retire=1; next instruction fetched on cycle 5.
- LW (0000011, funct3 010), mem_ready low for 2 MEM cycles → MEM lasts 3 cycles with iord=1, mem_we=0; reg_write in WB; 7 cycles total. SW (funct3 010) → mem_we=1, retire at the MEM handshake, no WB.
- BEQ with eq=1 → in EXEC brUn=1, pc_write=1, pc_sel=1, retire=1; back to FETCH. BGEU (funct3 111) with lt=1 → brUn=0, pc_sel=0.
- MEM_TIMEOUT=8, mem_ready held 0 in FETCH → after 8 FETCH cycles state=7, trap=1, mem_req=0; stays there until rst. Separately, mem_ready arriving on the 8th cycle → DECODE, no trap.
- Opcode 0000000, and BEQ-class opcode with funct3 010 → DECODE goes to TRAP, no retire. rst asserted mid-MEM → next cycle state=0, mem_req=0, no pc_write.
